axi_req_arbiter: RTL and testbench

Upstream of axi_master. Arbitrates the instruction-fetch port (IF) and the load/store port (LSU) onto axi_master's single command interface. At most one transaction is outstanding at a time. The block routes each completion and its read data back to the port that issued the request. It guards against a hung bus with a completion timeout, and prevents IF starvation with a bounded-priority counter.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/axi_arb_pick.sv | 40 ++++
 rtl/axi_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_axi_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and default constants for the IF/LSU request arbiter.
package axi_arb_pkg;

    localparam int unsigned TIMEOUT_DEF    = 255;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_R,
        ST_WAIT_W,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;

endpackage

// File: rtl/axi_arb_pick.sv
// Winner selection between IF and LSU with a saturating counter that
// bounds how many contested rounds the LSU may win in a row.
module axi_arb_pick
    import axi_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_ls_req,
    output logic o_if_gnt_c,
    output logic o_ls_gnt_c
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve;
    logic             w_starved;

    assign w_starved  = (r_starve == CNT_W'(STARVE_MAX));
    assign o_if_gnt_c = i_en & i_if_req & (~i_ls_req | w_starved);
    assign o_ls_gnt_c = i_en & i_ls_req & ~(i_if_req & w_starved);

    // Count LSU wins only while IF was actually waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (o_ls_gnt_c) begin
            if (!i_if_req)
                r_starve <= '0;
            else if (!w_starved)
                r_starve <= r_starve + CNT_W'(1);
        end else if (o_if_gnt_c) begin
            r_starve <= '0;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// Single-outstanding arbiter of IF and LSU requests onto the axi_master
// command interface, with completion routing and a bus-hang timeout.
module axi_req_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_ren,
    output logic                m_wen,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rdone,
    input  logic                m_wdone
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [STRB_W-1:0] r_m_wstrb;
    logic              r_m_ren;
    logic              r_m_wen;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_err;
    logic              r_ls_rvalid;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_ls_err;

    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_tmo_hit;

    axi_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk        (ACLK),
        .rst_n      (ARESETN),
        .i_en       (r_state == ST_IDLE),
        .i_if_req   (if_req),
        .i_ls_req   (ls_req),
        .o_if_gnt_c (w_if_gnt),
        .o_ls_gnt_c (w_ls_gnt)
    );

    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign ls_rvalid = r_ls_rvalid;
    assign ls_rdata  = r_ls_rdata;
    assign ls_err    = r_ls_err;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;
    assign m_ren     = r_m_ren;
    assign m_wen     = r_m_wen;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_tmo       <= '0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
            r_m_ren     <= 1'b0;
            r_m_wen     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= '0;
            r_ls_err    <= 1'b0;
        end else begin
            // Start strobes and completion pulses last exactly one cycle.
            r_m_ren     <= 1'b0;
            r_m_wen     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_if_gnt) begin
                        r_owner   <= OWN_IF;
                        r_we      <= 1'b0;
                        r_m_addr  <= if_addr;
                        r_m_wdata <= '0;
                        r_m_wstrb <= '0;
                        r_m_ren   <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end else if (w_ls_gnt) begin
                        r_owner   <= OWN_LS;
                        r_we      <= ls_we;
                        r_m_addr  <= ls_addr;
                        r_m_wdata <= ls_we ? ls_wdata : '0;
                        r_m_wstrb <= ls_we ? ls_wstrb : '0;
                        r_m_ren   <= ~ls_we;
                        r_m_wen   <= ls_we;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= r_we ? ST_WAIT_W : ST_WAIT_R;
                end

                ST_WAIT_R: begin
                    if (m_rdone || w_tmo_hit) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata  <= m_rdone ? m_rdata : '0;
                            r_if_err    <= ~m_rdone;
                            r_if_rvalid <= 1'b1;
                        end else begin
                            r_ls_rdata  <= m_rdone ? m_rdata : '0;
                            r_ls_err    <= ~m_rdone;
                            r_ls_rvalid <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                // Only the LSU can own a write.
                ST_WAIT_W: begin
                    if (m_wdone || w_tmo_hit) begin
                        r_ls_rdata  <= '0;
                        r_ls_err    <= ~m_wdone;
                        r_ls_rvalid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                ST_RESP: begin
                    r_if_err <= 1'b0;
                    r_ls_err <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter: expected commands and completions
// are queued as requests are driven and checked as the DUT produces them.
module tb_axi_req_arbiter;

    localparam int unsigned TMO = 255;

    typedef struct {
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct {
        bit          is_ls;
        logic [31:0] rdata;
        bit          err;
    } cpl_t;

    logic        ACLK, ARESETN;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_wstrb, m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ren, m_wen, m_rdone, m_wdone;

    logic        a_rdone, a_wdone, t_rdone, t_wdone;
    logic [31:0] a_rdata, t_rdata;
    int          sl_mode, sl_delay;
    logic [31:0] sl_data;

    cmd_t cmd_q[$];
    cpl_t cpl_q[$];
    cmd_t mc;
    cpl_t mp;
    int   n_chk, n_pass, cyc, gnt_cyc, ren_cyc, rv_cyc;
    logic prev_cmd, prev_if_rv, prev_ls_rv;

    assign m_rdone = a_rdone | t_rdone;
    assign m_wdone = a_wdone | t_wdone;
    assign m_rdata = t_rdone ? t_rdata : a_rdata;

    axi_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .STARVE_MAX(4)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_err(ls_err),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ren(m_ren),
        .m_wen(m_wen), .m_rdata(m_rdata), .m_rdone(m_rdone), .m_wdone(m_wdone)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge ACLK);
            cyc++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Bus responder: returns done sl_delay cycles after each start strobe.
    initial begin
        a_rdone = 1'b0; a_wdone = 1'b0; a_rdata = '0;
        forever begin
            @(posedge ACLK); #1;
            a_rdone = 1'b0; a_wdone = 1'b0;
            if (ARESETN && (m_ren || m_wen) && sl_mode == 0) begin
                automatic bit is_w = m_wen;
                repeat (sl_delay) begin @(posedge ACLK); #1; end
                a_rdata = is_w ? 32'h0 : sl_data;
                a_rdone = ~is_w;
                a_wdone = is_w;
            end
        end
    end

    // Output monitor: commands and completions against the scoreboard.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (if_gnt || ls_gnt) gnt_cyc = cyc;
            if (m_ren || m_wen) begin
                ren_cyc = cyc;
                check("cmd_lat", 64'(cyc - gnt_cyc), 64'd1);
                check("cmd_pulse", 64'(prev_cmd), 64'd0);
                if (cmd_q.size() == 0) check("cmd_stray", 64'd1, 64'd0);
                else begin
                    mc = cmd_q.pop_front();
                    check("cmd_kind", {62'd0, m_ren, m_wen}, {62'd0, ~mc.wen, mc.wen});
                    check("m_addr", 64'(m_addr), 64'(mc.addr));
                    check("m_wdata", 64'(m_wdata), 64'(mc.wdata));
                    check("m_wstrb", 64'(m_wstrb), 64'(mc.wstrb));
                end
            end
            if (if_rvalid || ls_rvalid) begin
                rv_cyc = cyc;
                check("rv_pulse", {62'd0, prev_if_rv & if_rvalid, prev_ls_rv & ls_rvalid}, 64'd0);
                if (cpl_q.size() == 0) check("rv_stray", 64'd1, 64'd0);
                else begin
                    mp = cpl_q.pop_front();
                    check("cpl_port", {62'd0, if_rvalid, ls_rvalid}, {62'd0, ~mp.is_ls, mp.is_ls});
                    check("cpl_rdata", 64'(if_rvalid ? if_rdata : ls_rdata), 64'(mp.rdata));
                    check("cpl_err", 64'(if_rvalid ? if_err : ls_err), 64'(mp.err));
                end
            end
            if (prev_if_rv && !if_rvalid) check("if_err_clr", 64'(if_err), 64'd0);
            if (prev_ls_rv && !ls_rvalid) check("ls_err_clr", 64'(ls_err), 64'd0);
        end
        prev_cmd   = m_ren | m_wen;
        prev_if_rv = if_rvalid;
        prev_ls_rv = ls_rvalid;
    end

    task automatic push(input bit wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit is_ls, input logic [31:0] rd, input bit er);
        cmd_q.push_back('{wen, a, wd, ws});
        cpl_q.push_back('{is_ls, rd, er});
    endtask

    task automatic wait_gnt(input bit ls);
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge ACLK);
            if (ls ? ls_gnt : if_gnt) ok = 1;
        end
        if (!ok) check("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic req_if(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
        wait_gnt(1'b0);
        @(posedge ACLK); #1;
        if_req = 1'b0;
    endtask

    task automatic req_ls(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_wstrb = ws;
        wait_gnt(1'b1);
        @(posedge ACLK); #1;
        ls_req = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge ACLK);
            if (cmd_q.size() == 0 && cpl_q.size() == 0) ok = 1;
        end
        if (!ok) check("drain_timeout", 64'(cpl_q.size()), 64'd0);
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {53'd0, if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err,
                              m_ren, m_wen, m_wstrb, 1'b0}, 64'd0);
        check({tag, "_rdata"}, {if_rdata, ls_rdata}, 64'd0);
        check({tag, "_m"}, {m_addr, m_wdata}, 64'd0);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; gnt_cyc = 0; ren_cyc = 0; rv_cyc = 0;
        prev_cmd = 0; prev_if_rv = 0; prev_ls_rv = 0;
        sl_mode = 0; sl_delay = 1; sl_data = '0;
        t_rdone = 0; t_wdone = 0; t_rdata = '0;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        ARESETN = 1'b0;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        // IF read, done three cycles after the start strobe
        sl_delay = 3; sl_data = 32'hDEAD_BEEF;
        push(0, 32'h0000_1000, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 0);
        req_if(32'h0000_1000);
        drain();
        check("if_lat", 64'(rv_cyc - gnt_cyc), 64'd5);

        // LSU write
        sl_delay = 2;
        push(1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 1, 32'h0, 0);
        req_ls(1, 32'h8000_0004, 32'h1234_5678, 4'b0011);
        drain();
        check("if_rdata_hold", 64'(if_rdata), 64'hDEAD_BEEF);

        // Reset while waiting for read data
        sl_mode = 1;
        cmd_q.push_back('{1'b0, 32'h0000_1000, 32'h0, 4'h0});
        req_if(32'h0000_1000);
        @(posedge ACLK); #1;
        @(posedge ACLK); #3;
        ARESETN = 1'b0;
        #1;
        check_all_zero("rst_wait");
        cmd_q.delete(); cpl_q.delete();
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        sl_mode = 0; sl_delay = 2; sl_data = 32'h0BAD_F00D;
        push(0, 32'h0000_1000, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 0);
        req_if(32'h0000_1000);
        drain();

        // Contention: both held, LSU wins four times then IF gets a turn
        sl_delay = 1; sl_data = 32'h5A5A_1234;
        for (int g = 0; g < 10; g++) begin
            automatic bit is_if = (g == 4 || g == 9);
            push(0, is_if ? 32'h0000_2000 : 32'h0000_3000, 32'h0, 4'h0, ~is_if, 32'h5A5A_1234, 0);
        end
        if_req = 1; if_addr = 32'h0000_2000;
        ls_req = 1; ls_we = 0; ls_addr = 32'h0000_3000; ls_wdata = 32'h77; ls_wstrb = 4'hF;
        for (int g = 0; g < 10; g++) begin
            automatic bit ok = 0;
            automatic bit is_if = (g == 4 || g == 9);
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge ACLK);
                if (if_gnt || ls_gnt) ok = 1;
            end
            check("gnt_order", {62'd0, if_gnt, ls_gnt}, is_if ? 64'd2 : 64'd1);
        end
        @(posedge ACLK); #1;
        if_req = 0; ls_req = 0;
        drain();

        // LSU read timeout, then IF is served normally
        sl_mode = 1;
        push(0, 32'h0000_4000, 32'h0, 4'h0, 1, 32'h0, 1);
        req_ls(0, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
        drain();
        check("tmo_lat", 64'(rv_cyc - ren_cyc), 64'(TMO + 1));
        sl_mode = 0; sl_delay = 1; sl_data = 32'h1357_9BDF;
        push(0, 32'h0000_5000, 32'h0, 4'h0, 0, 32'h1357_9BDF, 0);
        req_if(32'h0000_5000);
        drain();

        // Stray dones in IDLE, ISSUE and wrong type in WAIT_R are ignored
        sl_mode = 1;
        t_rdone = 1; t_wdone = 1; t_rdata = 32'hBAD0_0BAD;
        @(posedge ACLK); #1;
        t_rdone = 0; t_wdone = 0;
        repeat (3) @(posedge ACLK);
        #1;
        push(0, 32'h0000_6000, 32'h0, 4'h0, 1, 32'hC0FF_EE00, 0);
        ls_req = 1; ls_we = 0; ls_addr = 32'h0000_6000;
        wait_gnt(1'b1);
        @(posedge ACLK); #1;
        ls_req = 0; t_rdone = 1;
        @(posedge ACLK); #1;
        t_rdone = 0; t_wdone = 1;
        @(posedge ACLK); #1;
        t_wdone = 0;
        repeat (3) @(posedge ACLK);
        #1;
        check("stray_no_rv", 64'(cpl_q.size()), 64'd1);
        t_rdone = 1; t_rdata = 32'hC0FF_EE00;
        @(posedge ACLK); #1;
        t_rdone = 0;
        drain();

        repeat (3) @(posedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
